// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between the CPU control unit and alu_seq.
// Latency: none, wires only.
// Backpressure: busy from the slave side gates start; a start seen while busy is dropped.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  // Issue side (driven by the control unit)
  logic             start;
  logic [3:0]       mode;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             cin;
  // Result side (driven by the ALU)
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             cout;
  logic             zout;
  logic             nout;

  modport master (
    output start, mode, dataA, dataB, cin,
    input  busy, done, out, out_hi, cout, zout, nout
  );

  modport slave (
    input  start, mode, dataA, dataB, cin,
    output busy, done, out, out_hi, cout, zout, nout
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with multi-cycle variable shifts and shift-add unsigned multiply.
// Latency: done at c+1 for simple ops, c+1+amt for shifts, c+1+WIDTH for MUL.
// Backpressure: busy is high while an op executes; start is dropped (never queued) while busy.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  // Step counter must hold WIDTH for MUL, so it gets one more bit than SHW when needed.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] M_PASSB = 4'b0000;
  localparam logic [3:0] M_AND   = 4'b0001;
  localparam logic [3:0] M_OR    = 4'b0010;
  localparam logic [3:0] M_XOR   = 4'b0011;
  localparam logic [3:0] M_ADD   = 4'b0100;
  localparam logic [3:0] M_ADC   = 4'b0101;
  localparam logic [3:0] M_CMP   = 4'b0110;
  localparam logic [3:0] M_SUB   = 4'b0111;
  localparam logic [3:0] M_SBB   = 4'b1000;
  localparam logic [3:0] M_NOT   = 4'b1001;
  localparam logic [3:0] M_SLL   = 4'b1010;
  localparam logic [3:0] M_SRL   = 4'b1011;
  localparam logic [3:0] M_SRA   = 4'b1100;
  localparam logic [3:0] M_PASSA = 4'b1101;
  localparam logic [3:0] M_MUL   = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mode_q, mode_d;
  // a: shift working value, or multiplicand for MUL
  logic [WIDTH-1:0] a_q, a_d;
  // {hi,lo}: MUL partial product; lo starts as the multiplier and is consumed LSB first
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic             cout_q, cout_d;
  logic             zout_q, zout_d;
  logic             nout_q, nout_d;

  // Issue-side evaluation of the current inputs
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   r_sum;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_z;
  logic             r_n;
  logic             r_cmp;
  logic             r_multi;

  // One EXEC step of the latched op
  logic [WIDTH-1:0] st_a;
  logic             st_bit;
  logic [WIDTH:0]   st_sum;
  logic [WIDTH-1:0] st_hi;
  logic [WIDTH-1:0] st_lo;

  logic             accept;

  assign amt    = bus.dataB[SHW-1:0];
  // DONE is idle as far as issue goes, which allows back-to-back ops.
  assign accept = bus.start && (state_q != S_EXEC);

  assign bus.busy   = (state_q == S_EXEC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.out    = out_q;
  assign bus.out_hi = out_hi_q;
  assign bus.cout   = cout_q;
  assign bus.zout   = zout_q;
  assign bus.nout   = nout_q;

  // Single-cycle result and flags straight from the issue inputs; also flags multi-cycle ops
  always_comb begin
    r_sum   = '0;
    r_out   = '0;
    r_cout  = 1'b0;
    r_z     = 1'b0;
    r_n     = 1'b0;
    r_cmp   = 1'b0;
    r_multi = 1'b0;
    case (bus.mode)
      M_PASSB: r_out = bus.dataB;
      M_AND:   r_out = bus.dataA & bus.dataB;
      M_OR:    r_out = bus.dataA | bus.dataB;
      M_XOR:   r_out = bus.dataA ^ bus.dataB;
      M_NOT:   r_out = ~bus.dataA;
      M_ADD: begin
        r_sum  = {1'b0, bus.dataA} + {1'b0, bus.dataB};
        r_out  = r_sum[WIDTH-1:0];
        r_cout = r_sum[WIDTH];
      end
      M_ADC: begin
        r_sum  = {1'b0, bus.dataA} + {1'b0, bus.dataB} + {{WIDTH{1'b0}}, bus.cin};
        r_out  = r_sum[WIDTH-1:0];
        r_cout = r_sum[WIDTH];
      end
      M_CMP: begin
        r_cmp  = 1'b1;
        r_out  = bus.dataA;
        r_cout = (bus.dataA < bus.dataB);
        r_z    = (bus.dataA == bus.dataB);
        r_n    = ($signed(bus.dataA) < $signed(bus.dataB));
      end
      // The extra top bit of the difference is set exactly when a borrow occurs.
      M_SUB: begin
        r_sum  = {1'b0, bus.dataA} - {1'b0, bus.dataB};
        r_out  = r_sum[WIDTH-1:0];
        r_cout = r_sum[WIDTH];
      end
      M_SBB: begin
        r_sum  = {1'b0, bus.dataA} - {1'b0, bus.dataB} - {{WIDTH{1'b0}}, bus.cin};
        r_out  = r_sum[WIDTH-1:0];
        r_cout = r_sum[WIDTH];
      end
      // A zero-distance shift completes immediately with A unchanged and no carry.
      M_SLL, M_SRL, M_SRA: begin
        r_out   = bus.dataA;
        r_multi = (amt != '0);
      end
      M_PASSA: r_out = bus.dataA;
      M_MUL:   r_multi = 1'b1;
      default: r_out = '0;
    endcase
    if (!r_cmp) begin
      r_z = (r_out == '0);
      r_n = r_out[WIDTH-1];
    end
  end

  // One bit of shift, or one shift-add multiply step, on the latched operands
  always_comb begin
    st_a   = a_q;
    st_bit = 1'b0;
    st_sum = {1'b0, hi_q};
    st_hi  = hi_q;
    st_lo  = lo_q;
    case (mode_q)
      M_SLL: begin
        st_a   = {a_q[WIDTH-2:0], 1'b0};
        st_bit = a_q[WIDTH-1];
      end
      M_SRL: begin
        st_a   = {1'b0, a_q[WIDTH-1:1]};
        st_bit = a_q[0];
      end
      M_SRA: begin
        st_a   = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        st_bit = a_q[0];
      end
      M_MUL: begin
        if (lo_q[0]) begin
          st_sum = {1'b0, hi_q} + {1'b0, a_q};
        end
        st_hi = st_sum[WIDTH:1];
        st_lo = {st_sum[0], lo_q[WIDTH-1:1]};
      end
      default: st_a = a_q;
    endcase
  end

  // Next-state, operand latching and result capture
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    cout_d   = cout_q;
    zout_d   = zout_q;
    nout_d   = nout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (r_multi) begin
            state_d = S_EXEC;
            mode_d  = bus.mode;
            a_d     = bus.dataA;
            lo_d    = bus.dataB;
            hi_d    = '0;
            cnt_d   = (bus.mode == M_MUL) ? CW'(WIDTH) : CW'(amt);
          end else begin
            state_d  = S_DONE;
            out_d    = r_out;
            out_hi_d = '0;
            cout_d   = r_cout;
            zout_d   = r_z;
            nout_d   = r_n;
          end
        end
      end
      S_EXEC: begin
        a_d   = st_a;
        lo_d  = st_lo;
        hi_d  = st_hi;
        cnt_d = cnt_q - CW'(1);
        // The last step's result is captured directly so done lands the next cycle.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (mode_q == M_MUL) begin
            out_d    = st_lo;
            out_hi_d = st_hi;
            cout_d   = (st_hi != '0);
            zout_d   = ({st_hi, st_lo} == '0);
            nout_d   = st_hi[WIDTH-1];
          end else begin
            out_d    = st_a;
            out_hi_d = '0;
            cout_d   = st_bit;
            zout_d   = (st_a == '0);
            nout_d   = st_a[WIDTH-1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight and clears results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      a_q      <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      cout_q   <= 1'b0;
      zout_q   <= 1'b0;
      nout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      cout_q   <= cout_d;
      zout_q   <= zout_d;
      nout_q   <= nout_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, hand-timed multi-cycle sequences and random ops against a reference model.
// Latency: checks done timing relative to the accept cycle.
// Backpressure: exercises dropped starts while busy and back-to-back issue in the done cycle.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  logic rst16;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut   (.clk(clk), .rst(rst),   .bus(bus));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] out;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    int         lat;
  } res_t;

  typedef struct {
    logic [3:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] out;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the mode table.
  function automatic res_t model(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    res_t r;
    int   s;
    int   amt;
    r.out = 8'h00;
    r.hi  = 8'h00;
    r.c   = 1'b0;
    r.z   = 1'b0;
    r.n   = 1'b0;
    r.lat = 1;
    amt   = int'(b[2:0]);
    case (m)
      4'h0: r.out = b;
      4'h1: r.out = a & b;
      4'h2: r.out = a | b;
      4'h3: r.out = a ^ b;
      4'h9: r.out = ~a;
      4'h4: begin s = int'(a) + int'(b); r.out = s[7:0]; r.c = (s > 255); end
      4'h5: begin s = int'(a) + int'(b) + int'(ci); r.out = s[7:0]; r.c = (s > 255); end
      4'h7: begin s = int'(a) - int'(b); r.out = s[7:0]; r.c = (s < 0); end
      4'h8: begin s = int'(a) - int'(b) - int'(ci); r.out = s[7:0]; r.c = (s < 0); end
      4'h6: begin
        r.out = a;
        r.c   = (a < b);
        r.z   = (a == b);
        r.n   = ($signed(a) < $signed(b));
      end
      4'hA, 4'hB, 4'hC: begin
        r.out = a;
        if (amt != 0) begin
          r.lat = 1 + amt;
          if (m == 4'hA) begin
            r.out = a << amt;
            r.c   = a[8-amt];
          end else if (m == 4'hB) begin
            r.out = a >> amt;
            r.c   = a[amt-1];
          end else begin
            r.out = 8'($signed(a) >>> amt);
            r.c   = a[amt-1];
          end
        end
      end
      4'hD: r.out = a;
      4'hE: begin
        s     = int'(a) * int'(b);
        r.out = s[7:0];
        r.hi  = s[15:8];
        r.c   = (s[15:8] != 8'h00);
        r.lat = 9;
      end
      default: r.out = 8'h00;
    endcase
    if (m != 4'h6) begin
      if (m == 4'hE) begin
        r.z = ({r.hi, r.out} == 16'h0000);
        r.n = r.hi[7];
      end else begin
        r.z = (r.out == 8'h00);
        r.n = r.out[7];
      end
    end
    return r;
  endfunction

  // Issue one op, scramble inputs after acceptance, wait for done (bounded), checking busy.
  task automatic run_op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, output int lat);
    bus.mode  = m;
    bus.dataA = a;
    bus.dataB = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = 4'($urandom);
    bus.dataA = 8'($urandom);
    bus.dataB = 8'($urandom);
    bus.cin   = 1'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk("busy_exec", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic compare(input string tag, input res_t e, input int lat);
    chk({tag, "_lat"},  32'(lat),        32'(e.lat));
    chk({tag, "_out"},  32'(bus.out),    32'(e.out));
    chk({tag, "_hi"},   32'(bus.out_hi), 32'(e.hi));
    chk({tag, "_cout"}, 32'(bus.cout),   32'(e.c));
    chk({tag, "_zout"}, 32'(bus.zout),   32'(e.z));
    chk({tag, "_nout"}, 32'(bus.nout),   32'(e.n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    res_t e;
    int   lat;
    int   k;
    logic [3:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;

    //         mode   A      B      cin   out    hi     c     z     n     lat
    vecs[0]  = '{4'h4, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'h7, 8'h03, 8'h05, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1};
    vecs[2]  = '{4'h8, 8'h05, 8'h02, 1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h6, 8'h10, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1};
    vecs[4]  = '{4'h6, 8'h80, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{4'h6, 8'h7F, 8'h7F, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{4'hC, 8'h80, 8'h03, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 4};
    vecs[7]  = '{4'hA, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 2};
    vecs[8]  = '{4'hB, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'hE, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 9};
    vecs[10] = '{4'h5, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[11] = '{4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[12] = '{4'h9, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[13] = '{4'h0, 8'hAA, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[14] = '{4'hE, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9};
    vecs[15] = '{4'hB, 8'h81, 8'h07, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8};

    rst = 1'b1;
    rst16 = 1'b1;
    bus.start = 1'b0; bus.mode = 4'h0; bus.dataA = 8'h00; bus.dataB = 8'h00; bus.cin = 1'b0;
    bus16.start = 1'b0; bus16.mode = 4'h0; bus16.dataA = 16'h0; bus16.dataB = 16'h0; bus16.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_out",    32'(bus.out),    32'd0);
    chk("rst_out_hi", 32'(bus.out_hi), 32'd0);
    chk("rst_cout",   32'(bus.cout),   32'd0);
    chk("rst_zout",   32'(bus.zout),   32'd0);
    chk("rst_nout",   32'(bus.nout),   32'd0);
    rst = 1'b0;
    rst16 = 1'b0;
    @(posedge clk); #1;

    // Table vectors, each followed by an idle cycle to see done drop and outputs hold.
    for (int i = 0; i < 16; i++) begin
      e.out = vecs[i].out; e.hi = vecs[i].hi; e.c = vecs[i].c;
      e.z = vecs[i].z; e.n = vecs[i].n; e.lat = vecs[i].lat;
      run_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ci, lat);
      compare($sformatf("vec%0d", i), e, lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      chk($sformatf("vec%0d_hold", i),       32'(bus.out),  32'(vecs[i].out));
    end

    // MUL FF*FF with a dropped ADD at c+4 and a back-to-back ADD in the done cycle.
    bus.mode = 4'hE; bus.dataA = 8'hFF; bus.dataB = 8'hFF; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("mul_busy_c%0d", j), 32'(bus.busy), 32'd1);
      chk($sformatf("mul_done_c%0d", j), 32'(bus.done), 32'd0);
      if (j == 4) begin
        bus.mode = 4'h4; bus.dataA = 8'h01; bus.dataB = 8'h01; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("mul_done_c9", 32'(bus.done),   32'd1);
    chk("mul_busy_c9", 32'(bus.busy),   32'd0);
    chk("mul_out",     32'(bus.out),    32'h01);
    chk("mul_hi",      32'(bus.out_hi), 32'hFE);
    chk("mul_cout",    32'(bus.cout),   32'd1);
    bus.mode = 4'h4; bus.dataA = 8'h02; bus.dataB = 8'h03; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_done_c10", 32'(bus.done),   32'd1);
    chk("b2b_out",      32'(bus.out),    32'h05);
    chk("b2b_hi",       32'(bus.out_hi), 32'h00);
    chk("b2b_cout",     32'(bus.cout),   32'd0);
    @(posedge clk); #1;
    chk("b2b_done_c11", 32'(bus.done),   32'd0);
    chk("b2b_hold",     32'(bus.out),    32'h05);

    // WIDTH=16: full MUL, then a MUL aborted by reset at c+5.
    bus16.mode = 4'hE; bus16.dataA = 16'h1234; bus16.dataB = 16'h0002; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    k = 1;
    while (bus16.done !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("w16_mul_lat",  32'(k),            32'd17);
    chk("w16_mul_out",  32'(bus16.out),    32'h2468);
    chk("w16_mul_hi",   32'(bus16.out_hi), 32'h0000);
    chk("w16_mul_cout", 32'(bus16.cout),   32'd0);
    @(posedge clk); #1;
    bus16.mode = 4'hE; bus16.dataA = 16'h1234; bus16.dataB = 16'h0002; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("w16_busy_c5", 32'(bus16.busy), 32'd1);
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    chk("w16_rst_busy", 32'(bus16.busy),   32'd0);
    chk("w16_rst_done", 32'(bus16.done),   32'd0);
    chk("w16_rst_out",  32'(bus16.out),    32'd0);
    chk("w16_rst_hi",   32'(bus16.out_hi), 32'd0);
    chk("w16_rst_flag", 32'({bus16.cout, bus16.zout, bus16.nout}), 32'd0);
    bus16.mode = 4'hD; bus16.dataA = 16'h00AB; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    chk("w16_post_rst_done", 32'(bus16.done), 32'd1);
    chk("w16_post_rst_out",  32'(bus16.out),  32'h00AB);

    // Random ops against the reference model, occasionally with idle gaps.
    for (int i = 0; i < 300; i++) begin
      m  = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      e  = model(m, a, b, ci);
      run_op(m, a, b, ci, lat);
      compare($sformatf("rnd%0d_m%0h", i, m), e, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rnd_done_pulse", 32'(bus.done), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
